// File: rtl/cpu_mem_bank.sv
// CPU data memory: WIDTH x DEPTH flop array, one write port, one registered read port,
// and a background clear sequencer. Define CPU_MEM_BYPASS_EN for write-first forwarding.
module cpu_mem_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clr,
    output logic             busy
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [0:0]             state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   busy_q, busy_d;
    logic [WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic [WIDTH-1:0]       rd_word;
    logic                   idle;
    logic                   clr_we;
    logic                   wr_ok;

    assign idle   = (state_q == ST_IDLE);
    assign clr_we = (state_q == ST_CLEAR);
    // clr wins over a same-cycle write; out-of-range addresses match no word and drop out
    assign wr_ok  = idle & wr_en & ~clr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_word
            logic [WIDTH-1:0] word_q, word_d;

            always_comb begin
                word_d = word_q;
                if (clr_we && (ptr_q == AW'(gi))) begin
                    word_d = '0;
                end else if (wr_ok && (wr_addr == AW'(gi))) begin
                    word_d = wr_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign mem_flat[gi*WIDTH +: WIDTH] = word_q;
        end
    endgenerate

    // Unmatched (out-of-range) read addresses yield zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_word = mem_flat[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef CPU_MEM_BYPASS_EN
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    logic fwd_hit;
    assign fwd_hit = wr_ok && (wr_addr == rd_addr) && ({1'b0, wr_addr} < DEPTH_W);
`endif

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (idle && rd_en) begin
            rd_valid_d = 1'b1;
`ifdef CPU_MEM_BYPASS_EN
            rd_data_d  = fwd_hit ? wr_data : rd_word;
`else
            rd_data_d  = rd_word;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        if (idle) begin
            if (clr) begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        end else begin
            if (ptr_q == LAST_PTR) begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                busy_d  = 1'b0;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_cpu_mem_bank.sv
// Directed checks of cpu_mem_bank: a DEPTH=16 instance for the main sequence and a
// DEPTH=12 instance for out-of-range addressing.
module tb_cpu_mem_bank;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       wr_en, rd_en, clr;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid, busy;

    logic       wr_en12, rd_en12, clr12;
    logic [3:0] wr_addr12, rd_addr12;
    logic [7:0] wr_data12;
    logic [7:0] rd_data12;
    logic       rd_valid12, busy12;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_mem_bank #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .clr(clr), .busy(busy)
    );

    cpu_mem_bank #(.WIDTH(8), .DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en12), .wr_addr(wr_addr12), .wr_data(wr_data12),
        .rd_en(rd_en12), .rd_addr(rd_addr12),
        .rd_data(rd_data12), .rd_valid(rd_valid12),
        .clr(clr12), .busy(busy12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("check %-16s observed 0x%0h expected 0x%0h ok", tag, obs, exp);
        end else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        wr_en12 = 1'b0; rd_en12 = 1'b0; clr12 = 1'b0;
    endtask

    initial begin
        int  busy_cyc;
        bit  saw_valid;
        logic [7:0] exp_same;

        idle_inputs();
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        wr_addr12 = '0; rd_addr12 = '0; wr_data12 = '0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // write then read back
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        chk("wr_no_valid", 32'(rd_valid), 32'h0);
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        chk("rd3_data", 32'(rd_data), 32'hAA);
        chk("rd3_valid", 32'(rd_valid), 32'h1);
        tick();
        chk("idle_valid", 32'(rd_valid), 32'h0);
        chk("idle_hold", 32'(rd_data), 32'hAA);

        // same-cycle read and write to one address
`ifdef CPU_MEM_BYPASS_EN
        exp_same = 8'h55;
`else
        exp_same = 8'hAA;
`endif
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h55;
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        wr_en = 1'b0;
        chk("same_cyc_data", 32'(rd_data), 32'(exp_same));
        chk("same_cyc_valid", 32'(rd_valid), 32'h1);
        tick();
        rd_en = 1'b0;
        chk("after_same", 32'(rd_data), 32'h55);

        // fill every word with 0xFF
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'hFF;
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        rd_en = 1'b0;
        chk("fill_rd7", 32'(rd_data), 32'hFF);

        // clr together with a write (dropped) and a read (accepted, old data)
        clr = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
        rd_en = 1'b1; rd_addr = 4'd9;
        tick();
        clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'h1);
        chk("clr_rd_valid", 32'(rd_valid), 32'h1);
        chk("clr_rd_old", 32'(rd_data), 32'hFF);

        // accesses while busy are ignored
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h12;
        rd_en = 1'b1; rd_addr = 4'd5;
        busy_cyc = 1;
        saw_valid = 1'b0;
        while (busy === 1'b1 && busy_cyc < 40) begin
            tick();
            if (busy === 1'b1) busy_cyc++;
            if (rd_valid !== 1'b0) saw_valid = 1'b1;
        end
        idle_inputs();
        chk("busy_cycles", 32'(busy_cyc), 32'd16);
        chk("busy_no_valid", 32'(saw_valid), 32'h0);
        chk("busy_rd_hold", 32'(rd_data), 32'hFF);

        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            tick();
            chk($sformatf("clr_rd%0d", a), {23'h0, rd_valid, rd_data}, 32'h100);
        end
        rd_en = 1'b0;

        // DEPTH=12 instance: out-of-range write dropped, read returns zero
        wr_en12 = 1'b1; wr_addr12 = 4'd13; wr_data12 = 8'h99;
        tick();
        wr_en12 = 1'b1; wr_addr12 = 4'd11; wr_data12 = 8'h3C;
        rd_en12 = 1'b1; rd_addr12 = 4'd13;
        tick();
        wr_en12 = 1'b0;
        chk("d12_rd13_data", 32'(rd_data12), 32'h0);
        chk("d12_rd13_valid", 32'(rd_valid12), 32'h1);
        rd_addr12 = 4'd1;
        tick();
        chk("d12_rd1_alias", 32'(rd_data12), 32'h0);
        rd_addr12 = 4'd11;
        tick();
        rd_en12 = 1'b0;
        chk("d12_rd11", 32'(rd_data12), 32'h3C);

        // reset in the middle of a clear
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd4;
        tick();
        rd_en = 1'b0;
        chk("pre_rst_rd4", 32'(rd_data), 32'hA5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("mid_clr_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_rd_data", 32'(rd_data), 32'h0);
        chk("async_rd_valid", 32'(rd_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            tick();
            chk($sformatf("post_rst_rd%0d", a), {23'h0, rd_valid, rd_data}, 32'h100);
        end
        rd_en = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd9;
        tick();
        rd_en = 1'b0;
        chk("post_rst_wr_rd", {23'h0, rd_valid, rd_data}, 32'h13C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
